// File: rtl/seq_multiplier_if.sv
// Request/response bundle for the sequential multiplier: operands and control
// in, busy/done status and the double-width product out.
interface seq_multiplier_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  abort;
  logic                  signed_mode;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result_lo;
  logic [DATA_WIDTH-1:0] result_hi;

  modport master (
    output start, abort, signed_mode, op_a, op_b,
    input  busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, abort, signed_mode, op_a, op_b,
    output busy, done, result_lo, result_hi
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: one partial product per cycle on operand
// magnitudes, with the sign applied once in a final fix-up cycle.
module seq_multiplier #(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  seq_multiplier_if.slave    m
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [2*DATA_WIDTH-1:0] acc_r;
  logic                    neg_r;
  logic [DATA_WIDTH-1:0]   hi_r;
  logic [DATA_WIDTH-1:0]   lo_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    latch_s;
  logic [DATA_WIDTH-1:0]   addend_s;
  logic [DATA_WIDTH:0]     sum_s;
  logic [2*DATA_WIDTH-1:0] acc_step_s;
  logic [2*DATA_WIDTH-1:0] product_s;

  function automatic logic [DATA_WIDTH-1:0] magnitude(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  is_signed
  );
    if (is_signed && v[DATA_WIDTH-1]) begin
      return ~v + DATA_WIDTH'(1'b1);
    end else begin
      return v;
    end
  endfunction

  function automatic logic [2*DATA_WIDTH-1:0] apply_sign(
    input logic [2*DATA_WIDTH-1:0] v,
    input logic                    neg
  );
    if (neg) begin
      return ~v + (2*DATA_WIDTH)'(1'b1);
    end else begin
      return v;
    end
  endfunction

  // Next-state decode; abort outranks start everywhere.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (m.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (m.start) begin
          state_nxt_s = ST_RUN;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (m.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIX: begin
        if (m.abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // One shift-add step: the multiplier bit shifts out of the low half as the
  // partial sum (with its carry) shifts in from the top.
  always_comb begin
    addend_s   = acc_r[0] ? a_r : {DATA_WIDTH{1'b0}};
    sum_s      = {1'b0, acc_r[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, addend_s};
    acc_step_s = {sum_s, acc_r[DATA_WIDTH-1:1]};
    product_s  = apply_sign(acc_r, neg_r);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      a_r     <= {DATA_WIDTH{1'b0}};
      acc_r   <= {(2*DATA_WIDTH){1'b0}};
      neg_r   <= 1'b0;
      hi_r    <= {DATA_WIDTH{1'b0}};
      lo_r    <= {DATA_WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_FIX);
      done_r  <= (state_nxt_s == ST_DONE);
      if (latch_s) begin
        a_r   <= magnitude(m.op_a, m.signed_mode);
        acc_r <= {{DATA_WIDTH{1'b0}}, magnitude(m.op_b, m.signed_mode)};
        neg_r <= m.signed_mode & (m.op_a[DATA_WIDTH-1] ^ m.op_b[DATA_WIDTH-1]);
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_RUN) && !m.abort) begin
        acc_r <= acc_step_s;
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        acc_r <= acc_r;
        cnt_r <= cnt_r;
      end
      if ((state_r == ST_FIX) && !m.abort) begin
        hi_r <= product_s[2*DATA_WIDTH-1:DATA_WIDTH];
        lo_r <= product_s[DATA_WIDTH-1:0];
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end
  end

  assign m.busy      = busy_r;
  assign m.done      = done_r;
  assign m.result_hi = hi_r;
  assign m.result_lo = lo_r;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed corner cases plus random
// operands, checked against a plain-arithmetic product model.
module tb_seq_multiplier;
  localparam int DW = 32;

  typedef struct {
    logic [2*DW-1:0] prod;
    int              exp_cyc;
  } item_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  item_t q[$];
  logic [2*DW-1:0] last_res = '0;

  seq_multiplier_if #(.DATA_WIDTH(DW)) dif ();
  seq_multiplier #(.DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .m(dif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic sm);
    logic signed [2*DW-1:0] sa, sb;
    logic [2*DW-1:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    if (sm) return sa * sb;
    else    return ua * ub;
  endfunction

  task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations on done, checks latency, busy window and hold.
  always @(negedge clk) begin
    item_t it;
    if (!reset) begin
      if (dif.done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          it = q.pop_front();
          chk("product", {dif.result_hi, dif.result_lo}, it.prod);
          chk("done_cycle", 64'(cyc), 64'(it.exp_cyc));
          chk("busy_at_done", {63'd0, dif.busy}, 64'd0);
          last_res = it.prod;
        end
      end else if (q.size() > 0 && cyc >= q[0].exp_cyc) begin
        checks++; errors++;
        $display("FAIL missing_done: got done=0 expected 1 (cycle %0d)", cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && cyc >= q[0].exp_cyc - DW - 1 && cyc < q[0].exp_cyc)
        chk("busy_window", {63'd0, dif.busy}, 64'd1);
      if (dif.busy)
        chk("result_hold", {dif.result_hi, dif.result_lo}, last_res);
    end
  end

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sm, input bit push);
    item_t it;
    @(negedge clk);
    dif.op_a = a; dif.op_b = b; dif.signed_mode = sm; dif.start = 1'b1;
    if (push) begin
      it.prod = ref_mul(a, b, sm);
      it.exp_cyc = cyc + DW + 2;
      q.push_back(it);
    end
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_drain(input bit noise);
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (noise && q.size() > 0 && cyc <= q[0].exp_cyc - 2) begin
        dif.start = 1'($urandom_range(1));
        dif.op_a = $urandom; dif.op_b = $urandom;
        dif.signed_mode = 1'($urandom_range(1));
      end else begin
        dif.start = 1'b0;
      end
    end
    dif.start = 1'b0;
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_busy"}, {63'd0, dif.busy}, 64'd0);
    chk({name, "_done"}, {63'd0, dif.done}, 64'd0);
    chk({name, "_result"}, {dif.result_hi, dif.result_lo}, 64'd0);
  endtask

  initial begin
    item_t it;
    int c;
    dif.start = 1'b0; dif.abort = 1'b0; dif.signed_mode = 1'b0;
    dif.op_a = '0; dif.op_b = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) reset = 1'b0;

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_drain(1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 1'b1); wait_drain(1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_drain(1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1); wait_drain(1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1); wait_drain(1'b0);
    issue(32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1); wait_drain(1'b0);

    // Back-to-back: start held through DONE, operands changed during RUN.
    @(negedge clk);
    c = cyc;
    dif.op_a = 32'd3; dif.op_b = 32'd5; dif.signed_mode = 1'b0; dif.start = 1'b1;
    it.prod = 64'd15; it.exp_cyc = c + DW + 2; q.push_back(it);
    it.prod = 64'd42; it.exp_cyc = c + DW + 2 + 34; q.push_back(it);
    @(negedge clk);
    dif.op_a = 32'd6; dif.op_b = 32'd7;
    repeat (34) @(negedge clk);
    dif.start = 1'b0;
    wait_drain(1'b0);

    // Abort mid-RUN: no done, results kept.
    issue(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    dif.abort = 1'b1;
    @(negedge clk);
    dif.abort = 1'b0;
    chk("abort_busy", {63'd0, dif.busy}, 64'd0);
    chk("abort_result", {dif.result_hi, dif.result_lo}, last_res);
    repeat (40) @(negedge clk);

    // Abort alongside start in IDLE drops the start.
    dif.op_a = 32'd9; dif.op_b = 32'd9; dif.start = 1'b1; dif.abort = 1'b1;
    @(negedge clk);
    dif.start = 1'b0; dif.abort = 1'b0;
    chk("abort_start_busy", {63'd0, dif.busy}, 64'd0);
    repeat (40) @(negedge clk);

    // Reset at edge 20 of RUN.
    issue(32'd100, 32'd200, 1'b0, 1'b1);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    last_res = '0;
    check_zero("midrun_reset");
    @(negedge clk) reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd2, 32'd3, 1'b0, 1'b1); wait_drain(1'b0);

    for (int i = 0; i < 40; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(1)), 1'b1);
      wait_drain(1'b1);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
